xy_route_unit: RTL and testbench

- Parametrised, registered XY dimension-order route-compute stage for one mesh router input port.
- Sits between the input buffer and the switch allocator.
- Accepts flits over a valid/ready handshake and computes a one-hot output port from each head flit.
- Locks that port for the rest of the packet (wormhole) and forwards flits through one pipeline register.

---
 rtl/xy_route_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_xy_route_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_route_unit.sv
`default_nettype none
// ============================================================================
// Module      : xy_route_unit
// Description : Registered XY dimension-order route-compute stage for one
//               mesh router input port. A head flit is routed X first, then
//               Y. The chosen output port is held for the rest of the packet
//               (wormhole). Flits pass through one pipeline register with a
//               valid/ready handshake on both sides.
//
// Ports       : clk, rst        clock, asynchronous active-high reset
//               cur_x, cur_y    this router's coordinates, read on head accept
//               in_valid/ready  upstream handshake
//               in_flit         {head, tail, ..., dest_y, dest_x}
//               out_valid/ready downstream handshake
//               out_flit        registered flit, unmodified
//               out_port        one-hot {N, E, W, S, L}
//               locked          a multi-flit packet is in flight
//               pkt_cnt         number of tail flits delivered (wraps)
//               err             sticky routing error (ROUTE_CHECK_EN only)
//
// Options     : `define ROUTE_CHECK_EN adds the err output, routes
//               out-of-mesh destinations to local and flags orphan flits and
//               heads arriving mid-packet.
//
// Revision    : 1.0 - initial release
// ============================================================================
module xy_route_unit #(
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4,
    parameter int FLIT_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_W-1:0]    cur_x,
    input  logic [Y_W-1:0]    cur_y,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic [4:0]        out_port,
    output logic              locked,
    output logic [CNT_W-1:0]  pkt_cnt
`ifdef ROUTE_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    localparam logic [4:0] c_port_local = 5'b00001;
    localparam logic [4:0] c_port_south = 5'b00010;
    localparam logic [4:0] c_port_west  = 5'b00100;
    localparam logic [4:0] c_port_east  = 5'b01000;
    localparam logic [4:0] c_port_north = 5'b10000;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;
    logic [4:0]        r_out_port;
    logic [4:0]        r_route_q;
    logic [CNT_W-1:0]  r_pkt_cnt;

    logic              w_accept;
    logic              w_deliver;
    logic              w_head;
    logic              w_tail;
    logic [X_W-1:0]    w_dx;
    logic [Y_W-1:0]    w_dy;
    logic [4:0]        w_route;
    logic              w_fwd;
    logic              w_latch_route;
    logic [4:0]        w_port_sel;

    function automatic logic [4:0] xy_route(
        input logic [X_W-1:0] dx,
        input logic [Y_W-1:0] dy,
        input logic [X_W-1:0] cx,
        input logic [Y_W-1:0] cy
    );
        if (dx > cx)      return c_port_east;
        else if (dx < cx) return c_port_west;
        else if (dy > cy) return c_port_south;
        else if (dy < cy) return c_port_north;
        else              return c_port_local;
    endfunction

    assign w_head    = in_flit[FLIT_W-1];
    assign w_tail    = in_flit[FLIT_W-2];
    assign w_dx      = in_flit[X_W-1:0];
    assign w_dy      = in_flit[Y_W+X_W-1:X_W];

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_out_valid && out_ready;

`ifdef ROUTE_CHECK_EN
    // One extra bit so MESH_X == 2**X_W still compares correctly.
    localparam logic [X_W:0] c_mesh_x = (X_W+1)'(MESH_X);
    localparam logic [Y_W:0] c_mesh_y = (Y_W+1)'(MESH_Y);

    logic w_dest_oob;
    logic w_err_set;
    logic r_err;

    assign w_dest_oob = ({1'b0, w_dx} >= c_mesh_x) || ({1'b0, w_dy} >= c_mesh_y);
    assign w_route    = w_dest_oob ? c_port_local : xy_route(w_dx, w_dy, cur_x, cur_y);
    assign err        = r_err;
`else
    assign w_route    = xy_route(w_dx, w_dy, cur_x, cur_y);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && w_head && !w_tail) w_state_nxt = S_LOCKED;
            S_LOCKED: if (w_accept && w_tail)            w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd         = 1'b0;
        w_latch_route = 1'b0;
        w_port_sel    = r_route_q;
`ifdef ROUTE_CHECK_EN
        w_err_set     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // Non-head flits in IDLE are orphans: consumed, never forwarded.
                if (w_accept && w_head) begin
                    w_fwd         = 1'b1;
                    w_latch_route = 1'b1;
                    w_port_sel    = w_route;
                end
`ifdef ROUTE_CHECK_EN
                if (w_accept) w_err_set = w_head ? w_dest_oob : 1'b1;
`endif
            end
            S_LOCKED: begin
                // Mid-packet flits follow the held route; their dest is ignored.
                if (w_accept) begin
                    w_fwd = 1'b1;
`ifdef ROUTE_CHECK_EN
                    w_err_set = w_head;
`endif
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline register, held route and packet counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_port  <= '0;
            r_route_q   <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            // A new flit overwrites the slot even when the old one leaves on
            // the same edge, so there is no bubble.
            if (w_fwd) begin
                r_out_valid <= 1'b1;
                r_out_flit  <= in_flit;
                r_out_port  <= w_port_sel;
            end else if (w_deliver) begin
                r_out_valid <= 1'b0;
            end
            if (w_latch_route) begin
                r_route_q <= w_route;
            end
            if (w_deliver && r_out_flit[FLIT_W-2]) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ROUTE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign out_port  = r_out_port;
    assign locked    = (r_state == S_LOCKED);
    assign pkt_cnt   = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xy_route_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_xy_route_unit
// Description : Self-checking bench for xy_route_unit. Directed packet
//               scenarios followed by randomized traffic, every cycle compared
//               against a packet-level reference model of the route stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xy_route_unit;

    localparam int X_W    = 2;
    localparam int Y_W    = 2;
`ifdef ROUTE_CHECK_EN
    localparam int MESH_X = 3;
`else
    localparam int MESH_X = 4;
`endif
    localparam int MESH_Y = 4;
    localparam int FLIT_W = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] in_flit;
    logic              out_valid;
    logic              out_ready;
    logic [FLIT_W-1:0] out_flit;
    logic [4:0]        out_port;
    logic              locked;
    logic [CNT_W-1:0]  pkt_cnt;
`ifdef ROUTE_CHECK_EN
    logic              err;
`endif

    xy_route_unit #(
        .X_W(X_W), .Y_W(Y_W), .MESH_X(MESH_X), .MESH_Y(MESH_Y),
        .FLIT_W(FLIT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cur_x(cur_x), .cur_y(cur_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
        .out_port(out_port), .locked(locked), .pkt_cnt(pkt_cnt)
`ifdef ROUTE_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: what sits in the output slot, and packet context.
    bit               m_occ;
    logic [FLIT_W-1:0] m_flit;
    logic [4:0]       m_port;
    bit               m_pkt;
    logic [4:0]       m_route;
    logic [CNT_W-1:0] m_cnt;
    bit               m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // XY rule: X first, then Y; one-hot {N, E, W, S, L}.
    function automatic logic [4:0] ref_port(input int dx, input int dy, input int cx, input int cy);
`ifdef ROUTE_CHECK_EN
        if (dx >= MESH_X || dy >= MESH_Y) return 5'b00001;
`endif
        if (dx > cx) return 5'b01000;
        if (dx < cx) return 5'b00100;
        if (dy > cy) return 5'b00010;
        if (dy < cy) return 5'b10000;
        return 5'b00001;
    endfunction

    function automatic logic [FLIT_W-1:0] mk(input bit h, input bit t, input int dx, input int dy);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[FLIT_W-1] = h;
        f[FLIT_W-2] = t;
        f[X_W-1:0] = dx[X_W-1:0];
        f[Y_W+X_W-1:X_W] = dy[Y_W-1:0];
        return f;
    endfunction

    task automatic model_reset();
        m_occ = 0; m_flit = '0; m_port = '0; m_pkt = 0; m_route = '0; m_cnt = '0; m_err = 0;
    endtask

    // Called at posedge+1. Drives one cycle, checks outputs, advances model.
    task automatic cycle(input bit v, input logic [FLIT_W-1:0] f, input bit ordy, output bit acc);
        bit exp_rdy, dlv;
        in_valid = v; in_flit = f; out_ready = ordy;
        #1;
        exp_rdy = !m_occ || ordy;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_occ);
        if (m_occ) begin
            chk("out_flit", out_flit, m_flit);
            chk("out_port", out_port, m_port);
        end
        chk("locked", locked, m_pkt);
        chk("pkt_cnt", pkt_cnt, m_cnt);
`ifdef ROUTE_CHECK_EN
        chk("err", err, m_err);
`endif
        acc = v && exp_rdy;
        dlv = m_occ && ordy;
        if (dlv) begin
            if (m_flit[FLIT_W-2]) m_cnt = m_cnt + 1'b1;
            m_occ = 0;
        end
        if (acc) begin
            if (!m_pkt) begin
                if (f[FLIT_W-1]) begin
                    m_occ  = 1;
                    m_flit = f;
                    m_port = ref_port(int'(f[X_W-1:0]), int'(f[Y_W+X_W-1:X_W]), int'(cur_x), int'(cur_y));
                    if (int'(f[X_W-1:0]) >= MESH_X || int'(f[Y_W+X_W-1:X_W]) >= MESH_Y) m_err = 1;
                    if (!f[FLIT_W-2]) begin
                        m_pkt   = 1;
                        m_route = m_port;
                    end
                end else begin
                    m_err = 1;
                end
            end else begin
                m_occ  = 1;
                m_flit = f;
                m_port = m_route;
                if (f[FLIT_W-1]) m_err = 1;
                if (f[FLIT_W-2]) m_pkt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input logic [FLIT_W-1:0] f, input bit ordy);
        bit acc;
        cycle(v, f, ordy, acc);
    endtask

    int d1x [5] = '{1, 3, 0, 1, 1};
    int d1y [5] = '{1, 1, 1, 3, 0};
    logic [FLIT_W-1:0] pk [4];
    bit ord_pat [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        bit acc;
        int idx;
        rst = 1; cur_x = '0; cur_y = '0; in_valid = 0; in_flit = '0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_out_port", out_port, 0);
        chk("rst_locked", locked, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        rst = 0;

        // Single-flit packets around (1,1).
        cur_x = 1; cur_y = 1;
        for (int i = 0; i < 5; i++) step(1, mk(1, 1, d1x[i], d1y[i]), 1);
        step(0, '0, 1);
        chk("plan1_cnt", pkt_cnt, 5);

        // Four-flit wormhole packet from (0,0) to (2,3).
        cur_x = 0; cur_y = 0;
        step(1, mk(1, 0, 2, 3), 1);
        step(1, mk(0, 0, 0, 0), 1);
        step(1, mk(0, 0, 0, 0), 1);
        step(1, mk(0, 1, 0, 0), 1);
        step(0, '0, 1);
        chk("plan2_cnt", pkt_cnt, 6);

        // Continuous packet with a three-cycle downstream stall.
        cur_x = 1; cur_y = 2;
        pk[0] = mk(1, 0, 0, 2); pk[1] = 16'h0123; pk[2] = 16'h0abc; pk[3] = mk(0, 1, 3, 3);
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) begin
                cycle(1, pk[idx], ord_pat[c], acc);
                if (acc) idx++;
            end else begin
                step(0, '0, ord_pat[c]);
            end
        end
        chk("stall_all_accepted", idx, 4);
        chk("plan3_cnt", pkt_cnt, 7);

        // Asynchronous reset mid-packet with a flit in the output slot.
        cur_x = 0; cur_y = 0;
        step(1, mk(1, 0, 3, 3), 1);
        step(1, mk(0, 0, 1, 1), 0);
        in_valid = 0;
        rst = 1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_locked", locked, 0);
        chk("arst_pkt_cnt", pkt_cnt, 0);
        model_reset();
        #2 rst = 0;
        @(posedge clk);
        #1;
        step(1, mk(1, 1, 2, 0), 1);
        step(0, '0, 1);

        // Orphan body flit in IDLE, then a head heading north.
        cur_x = 3; cur_y = 2;
        step(1, mk(0, 0, 1, 1), 1);
        step(1, mk(1, 1, 3, 0), 1);
        step(0, '0, 1);

`ifdef ROUTE_CHECK_EN
        // Out-of-mesh destination goes local and sets the sticky error.
        cur_x = 1; cur_y = 1;
        step(1, mk(1, 1, 3, 0), 1);
        step(0, '0, 1);
        step(1, mk(1, 1, 2, 1), 1);
        step(0, '0, 1);
        chk("err_sticky", err, 1);
`endif

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(19) == 0) begin
                cur_x = X_W'($urandom);
                cur_y = Y_W'($urandom);
            end
            step($urandom_range(9) < 7,
                 mk($urandom_range(9) < 4, $urandom_range(9) < 4,
                    int'($urandom_range(3)), int'($urandom_range(3))) | FLIT_W'({$urandom} & 32'h0ff0),
                 $urandom_range(3) != 0);
        end
        repeat (3) step(0, '0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
